mem_access_unit: RTL and testbench

//  Load/store front end between the EX/MEM pipeline register and DataMemory.
//  - Word accesses pass straight through.
//  - Byte/halfword stores run a 2-cycle read-modify-write, stalling the pipeline for one cycle.
//  - Loads are extracted and sign/zero-extended combinationally.
//  - Little-endian lanes: byte k = word bits [8k+7:8k].

---
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store front end between EX/MEM and DataMemory: word pass-through,
// sub-word store read-modify-write, and sign/zero-extended sub-word loads.
// Ports:
//   Clk, Reset (async, active-high).
//   Address, StoreData, MemRead, MemWrite, MemSize, LoadSigned come from EX/MEM.
//   LoadData goes to MEM/WB.
//   Stall holds the front of the pipeline.
//   Misaligned flags an access that is not aligned to its size.
//   DM_Address, DM_WriteData, DM_MemWrite, DM_MemRead, DM_ReadData connect to DataMemory.
// Optional feature: define MISALIGN_TRAP_EN to flag and suppress misaligned accesses.
//   When it is undefined, the low address bits are ignored.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] StoreData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              LoadSigned,
  output logic [DATA_W-1:0] LoadData,
  output logic              Stall,
  output logic              Misaligned,
  output logic [ADDR_W-1:0] DM_Address,
  output logic [DATA_W-1:0] DM_WriteData,
  output logic              DM_MemWrite,
  output logic              DM_MemRead,
  input  logic [DATA_W-1:0] DM_ReadData
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              is_half;
  logic              is_byte;
  logic              is_word;
  logic              mis;
  logic [ADDR_W-1:0] aligned;
  logic [DATA_W-1:0] merged;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] load_ext;

  assign is_half = (MemSize == 2'b01);
  assign is_byte = (MemSize == 2'b10);
  // Reserved size 11 behaves as a word access.
  assign is_word = !is_half && !is_byte;
  assign aligned = {Address[ADDR_W-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  // Only a live access in IDLE can be misaligned.
  assign mis = !Reset && (state_q == IDLE) && (MemRead || MemWrite) &&
               ((is_half && Address[0]) ||
                (is_word && (Address[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  assign Misaligned = mis;

  // Lane merge for sub-word stores and lane extract for loads
  always_comb begin
    merged = DM_ReadData;
    byte_v = DM_ReadData[7:0];
    half_v = Address[1] ? DM_ReadData[31:16] : DM_ReadData[15:0];
    unique case (Address[1:0])
      2'b00: byte_v = DM_ReadData[7:0];
      2'b01: byte_v = DM_ReadData[15:8];
      2'b10: byte_v = DM_ReadData[23:16];
      2'b11: byte_v = DM_ReadData[31:24];
    endcase
    if (is_byte) begin
      unique case (Address[1:0])
        2'b00: merged[7:0]   = StoreData[7:0];
        2'b01: merged[15:8]  = StoreData[7:0];
        2'b10: merged[23:16] = StoreData[7:0];
        2'b11: merged[31:24] = StoreData[7:0];
      endcase
    end else if (Address[1]) begin
      merged[31:16] = StoreData[15:0];
    end else begin
      merged[15:0] = StoreData[15:0];
    end
    unique case (1'b1)
      is_byte: load_ext = {{24{LoadSigned & byte_v[7]}}, byte_v};
      is_half: load_ext = {{16{LoadSigned & half_v[15]}}, half_v};
      default: load_ext = DM_ReadData;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wdata_d      = wdata_q;
    addr_d       = addr_q;
    Stall        = 1'b0;
    DM_MemWrite  = 1'b0;
    DM_MemRead   = 1'b0;
    DM_WriteData = StoreData;
    DM_Address   = aligned;
    LoadData     = '0;
    // Holding Reset keeps every strobe low, even mid read-modify-write.
    if (!Reset) begin
      unique case (state_q)
        RMW_WR: begin
          DM_Address   = addr_q;
          DM_WriteData = wdata_q;
          DM_MemWrite  = 1'b1;
          state_d      = IDLE;
        end
        IDLE: begin
          if (mis) begin
            state_d = IDLE;
          end else if (MemWrite) begin
            if (is_word) begin
              DM_MemWrite = 1'b1;
            end else begin
              DM_MemRead = 1'b1;
              Stall      = 1'b1;
              wdata_d    = merged;
              addr_d     = aligned;
              state_d    = RMW_WR;
            end
          end else if (MemRead) begin
            DM_MemRead = 1'b1;
            LoadData   = load_ext;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural DataMemory.
// Table-driven load vectors plus hand-written store/reset sequences.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic        mrd;
  logic        mwr;
  logic [1:0]  msize;
  logic        lsgn;
  logic [31:0] ldata;
  logic        stall;
  logic        mis;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_wr;
  logic        dm_rd;
  logic [31:0] dm_rdata;

  logic [31:0] mem [0:63];

  int n_cmp;
  int n_err;

  mem_access_unit dut (
    .Clk          (clk),
    .Reset        (rst),
    .Address      (addr),
    .StoreData    (sdata),
    .MemRead      (mrd),
    .MemWrite     (mwr),
    .MemSize      (msize),
    .LoadSigned   (lsgn),
    .LoadData     (ldata),
    .Stall        (stall),
    .Misaligned   (mis),
    .DM_Address   (dm_addr),
    .DM_WriteData (dm_wdata),
    .DM_MemWrite  (dm_wr),
    .DM_MemRead   (dm_rd),
    .DM_ReadData  (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_rdata = mem[dm_addr[7:2]];

  always @(posedge clk) begin
    if (dm_wr) mem[dm_addr[7:2]] <= dm_wdata;
  end

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rd;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] exp_ld;
    logic        exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic r, input logic w,
                       input logic [1:0] s, input logic g);
    addr  = a;
    sdata = d;
    mrd   = r;
    mwr   = w;
    msize = s;
    lsgn  = g;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'hCAFEF00D;
    mem[8]  = 32'h11223344;
    mem[12] = 32'h80FF7F01;

    vecs[0]  = '{"lb_31_s",  32'h31, 1, 2'b10, 1, 32'h0000007F, 1, 0};
    vecs[1]  = '{"lbu_31",   32'h31, 1, 2'b10, 0, 32'h0000007F, 1, 0};
    vecs[2]  = '{"lb_32_s",  32'h32, 1, 2'b10, 1, 32'hFFFFFFFF, 1, 0};
    vecs[3]  = '{"lbu_32",   32'h32, 1, 2'b10, 0, 32'h000000FF, 1, 0};
    vecs[4]  = '{"lb_33_s",  32'h33, 1, 2'b10, 1, 32'hFFFFFF80, 1, 0};
    vecs[5]  = '{"lb_30_s",  32'h30, 1, 2'b10, 1, 32'h00000001, 1, 0};
    vecs[6]  = '{"lh_30_s",  32'h30, 1, 2'b01, 1, 32'h00007F01, 1, 0};
    vecs[7]  = '{"lh_32_s",  32'h32, 1, 2'b01, 1, 32'hFFFF80FF, 1, 0};
    vecs[8]  = '{"lhu_32",   32'h32, 1, 2'b01, 0, 32'h000080FF, 1, 0};
    vecs[9]  = '{"lw_30",    32'h30, 1, 2'b00, 1, 32'h80FF7F01, 1, 0};
    vecs[10] = '{"no_req",   32'h31, 0, 2'b10, 1, 32'h00000000, 0, 0};
    vecs[11] = '{"lw_rsv",   32'h20, 1, 2'b11, 0, 32'h11223344, 1, 0};
`ifdef MISALIGN_TRAP_EN
    vecs[12] = '{"lh_21_mis", 32'h21, 1, 2'b01, 1, 32'h0, 0, 1};
    vecs[13] = '{"lw_13_mis", 32'h13, 1, 2'b00, 0, 32'h0, 0, 1};
`else
    vecs[12] = '{"lh_21_al", 32'h21, 1, 2'b01, 1, 32'h00003344, 1, 0};
    vecs[13] = '{"lw_13_al", 32'h13, 1, 2'b00, 0, 32'hCAFEF00D, 1, 0};
`endif

    rst = 1'b1;
    drive(32'h0, 32'h0, 0, 0, 2'b00, 0);
    #2;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_dm_wr", {31'b0, dm_wr}, 32'h0);
    chk("rst_dm_rd", {31'b0, dm_rd}, 32'h0);
    chk("rst_mis",   {31'b0, mis},   32'h0);
    chk("rst_ld",    ldata,          32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].addr, 32'h0, vecs[i].rd, 0, vecs[i].size, vecs[i].sgn);
      #1;
      chk({vecs[i].name, "_ld"}, ldata, vecs[i].exp_ld);
      chk({vecs[i].name, "_rd"}, {31'b0, dm_rd}, {31'b0, vecs[i].exp_rd});
      chk({vecs[i].name, "_mis"}, {31'b0, mis}, {31'b0, vecs[i].exp_mis});
      chk({vecs[i].name, "_stall"}, {31'b0, stall}, 32'h0);
      chk({vecs[i].name, "_wr"}, {31'b0, dm_wr}, 32'h0);
      if (vecs[i].exp_rd)
        chk({vecs[i].name, "_addr"}, dm_addr,
            {vecs[i].addr[31:2], 2'b00});
    end

    // Word store then word load: no stall, one-cycle write latency
    @(negedge clk);
    drive(32'h10, 32'hDEADBEEF, 0, 1, 2'b00, 0);
    #1;
    chk("sw_stall", {31'b0, stall}, 32'h0);
    chk("sw_wr",    {31'b0, dm_wr}, 32'h1);
    chk("sw_wdata", dm_wdata, 32'hDEADBEEF);
    chk("sw_addr",  dm_addr,  32'h10);
    @(negedge clk);
    drive(32'h10, 32'h0, 1, 0, 2'b00, 0);
    #1;
    chk("lw_stall", {31'b0, stall}, 32'h0);
    chk("lw_10",    ldata, 32'hDEADBEEF);

    // Byte store 0xAB @0x21 over 0x11223344
    @(negedge clk);
    drive(32'h21, 32'h000000AB, 0, 1, 2'b10, 0);
    #1;
    chk("sb_c0_stall", {31'b0, stall}, 32'h1);
    chk("sb_c0_rd",    {31'b0, dm_rd}, 32'h1);
    chk("sb_c0_wr",    {31'b0, dm_wr}, 32'h0);
    @(negedge clk);
    #1;
    chk("sb_c1_stall", {31'b0, stall}, 32'h0);
    chk("sb_c1_wr",    {31'b0, dm_wr}, 32'h1);
    chk("sb_c1_wdata", dm_wdata, 32'h1122AB44);
    chk("sb_c1_addr",  dm_addr,  32'h20);
    @(negedge clk);
    drive(32'h0, 32'h0, 0, 0, 2'b00, 0);
    #1;
    chk("sb_c2_stall", {31'b0, stall}, 32'h0);
    chk("sb_c2_wr",    {31'b0, dm_wr}, 32'h0);
    chk("sb_mem",      mem[8], 32'h1122AB44);

    // Half store 0xBEEF @0x22 over 0x11223344, then signed half load
    mem[8] = 32'h11223344;
    @(negedge clk);
    drive(32'h22, 32'h1234BEEF, 0, 1, 2'b01, 0);
    #1;
    chk("sh_c0_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    #1;
    chk("sh_c1_wdata", dm_wdata, 32'hBEEF3344);
    @(negedge clk);
    drive(32'h22, 32'h0, 1, 0, 2'b01, 1);
    #1;
    chk("sh_mem",   mem[8], 32'hBEEF3344);
    chk("lh_22_s",  ldata,  32'hFFFFBEEF);

    // Reset while in RMW_WR drops the pending store
    @(negedge clk);
    drive(32'h40, 32'h00000055, 0, 1, 2'b10, 0);
    #1;
    chk("rr_c0_stall", {31'b0, stall}, 32'h1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rr_rst_wr",    {31'b0, dm_wr}, 32'h0);
    chk("rr_rst_stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(32'h0, 32'h0, 0, 0, 2'b00, 0);
    #1;
    chk("rr_idle_wr", {31'b0, dm_wr}, 32'h0);
    chk("rr_mem",     mem[16], 32'h0);
    @(negedge clk);
    drive(32'h40, 32'h0, 1, 0, 2'b10, 0);
    #1;
    chk("rr_ld",    ldata, 32'h0);
    chk("rr_stall", {31'b0, stall}, 32'h0);
    chk("rr_rd",    {31'b0, dm_rd}, 32'h1);

    // Load and store both high: the store wins, LoadData stays 0
    @(negedge clk);
    drive(32'h10, 32'h01020304, 1, 1, 2'b00, 0);
    #1;
    chk("rw_ld", ldata, 32'h0);
    chk("rw_wr", {31'b0, dm_wr}, 32'h1);
    chk("rw_rd", {31'b0, dm_rd}, 32'h0);
    @(negedge clk);
    drive(32'h0, 32'h0, 0, 0, 2'b00, 0);
    #1;
    chk("rw_mem", mem[4], 32'h01020304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
